apb_pwm_cap: RTL and testbench

APB-slave input-capture block sitting directly downstream of the PWM generator. It samples a PWM waveform, normally loop-backed from `PWM01` or taken from an external pin, and measures the high time and period in `apb_pclk` cycles. It exposes the results, status flags and an interrupt through APB registers at offsets 0x40–0x50, alongside the PWM block's 0x30–0x3C window.

---
 rtl/pwm_cap_pkg.sv | 36 +++
 rtl/pwm_cap_sync.sv | 39 +++
 rtl/apb_pwm_cap.sv | 170 +++++++++++++++++
 tb/tb_apb_pwm_cap.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cap_pkg.sv
// ============================================================================
// Module   : pwm_cap_pkg
// Purpose  : Register map, bit positions and FSM encoding for apb_pwm_cap.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pwm_cap_pkg;

    localparam logic [7:0] c_off_ctrl    = 8'h40;
    localparam logic [7:0] c_off_status  = 8'h44;
    localparam logic [7:0] c_off_period  = 8'h48;
    localparam logic [7:0] c_off_high    = 8'h4C;
    localparam logic [7:0] c_off_timeout = 8'h50;

    localparam int c_ctrl_en      = 0;
    localparam int c_ctrl_irq_en  = 1;
    localparam int c_ctrl_oneshot = 2;

    localparam int c_st_valid = 0;
    localparam int c_st_ovr   = 1;
    localparam int c_st_tmo   = 2;

    localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_DONE = 3'd4
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_cap_sync.sv
// ============================================================================
// Module   : pwm_cap_sync
// Purpose  : Multi-flop synchronizer plus history flop with rise/fall strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_cap_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cap_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], cap_in};
            r_s_d  <= w_s;
        end
    end

    assign rise = w_s & ~r_s_d;
    assign fall = ~w_s & r_s_d;

endmodule

`default_nettype wire

// File: rtl/apb_pwm_cap.sv
// ============================================================================
// Module   : apb_pwm_cap
// Purpose  : APB input-capture measuring high time and period of a waveform.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_pwm_cap
    import pwm_cap_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        apb_pclk,
    input  logic        apb_prstn,
    input  logic        apb_psel,
    input  logic [31:0] apb_paddr,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    input  logic        cap_in,
    output logic        irq
);

    logic [2:0]  r_ctrl;
    logic [2:0]  r_status;
    logic [31:0] r_period;
    logic [31:0] r_high;
    logic [31:0] r_timeout;
    logic [31:0] r_cnt;
    logic [31:0] r_hi_tmp;
    cap_state_t  r_state;

    logic        w_rise;
    logic        w_fall;
    logic        w_wr;
    logic [7:0]  w_addr;
    logic [31:0] w_cnt_inc;
    logic        w_tmo_evt;
    logic        w_done;
    logic [2:0]  w_status_clr;
    logic [2:0]  w_status_set;
    logic        w_unused_paddr;

    pwm_cap_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (apb_pclk),
        .rst_n  (apb_prstn),
        .cap_in (cap_in),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_addr         = apb_paddr[7:0];
    assign w_unused_paddr = &{1'b0, apb_paddr[31:8]};
    assign w_wr           = apb_psel & apb_penable & apb_pwrite;
    assign w_cnt_inc      = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 32'd1;

    // Timeout overrides an edge seen in the same cycle.
    always_comb begin
        w_tmo_evt = r_ctrl[c_ctrl_en] && ((r_state == ST_HI) || (r_state == ST_LO))
                    && (r_timeout != 32'd0) && (r_cnt == r_timeout);
        w_done    = r_ctrl[c_ctrl_en] && (r_state == ST_LO) && !w_tmo_evt && w_rise;
    end

    always_comb begin
        w_status_clr = 3'b000;
        if (w_wr && (w_addr == c_off_status)) begin
            w_status_clr = apb_pwdata[2:0];
        end
        w_status_set             = 3'b000;
        w_status_set[c_st_valid] = w_done;
        w_status_set[c_st_ovr]   = w_done & r_status[c_st_valid];
        w_status_set[c_st_tmo]   = w_tmo_evt;
    end

    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) begin
            r_ctrl    <= 3'b000;
            r_timeout <= 32'd0;
            r_status  <= 3'b000;
        end else begin
            if (w_wr && (w_addr == c_off_ctrl)) begin
                r_ctrl <= apb_pwdata[2:0];
            end
            if (w_wr && (w_addr == c_off_timeout)) begin
                r_timeout <= apb_pwdata;
            end
            r_status <= (r_status & ~w_status_clr) | w_status_set;
        end
    end

    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_period <= 32'd0;
            r_high   <= 32'd0;
        end else if (!r_ctrl[c_ctrl_en]) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= 32'd0;
                    r_state <= ST_ARM;
                end
                ST_ARM: begin
                    if (w_rise) begin
                        r_cnt   <= 32'd1;
                        r_state <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (w_tmo_evt) begin
                        r_cnt   <= 32'd0;
                        r_state <= ST_ARM;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_fall) begin
                            r_hi_tmp <= r_cnt;
                            r_state  <= ST_LO;
                        end
                    end
                end
                ST_LO: begin
                    if (w_tmo_evt) begin
                        r_cnt   <= 32'd0;
                        r_state <= ST_ARM;
                    end else if (w_done) begin
                        r_period <= r_cnt;
                        r_high   <= r_hi_tmp;
                        r_cnt    <= 32'd1;
                        r_state  <= r_ctrl[c_ctrl_oneshot] ? ST_DONE : ST_HI;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    r_cnt <= 32'd0;
                end
                default: begin
                    r_cnt   <= 32'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        apb_prdata = 32'd0;
        if (apb_psel && !apb_pwrite) begin
            case (w_addr)
                c_off_ctrl:    apb_prdata = {29'd0, r_ctrl};
                c_off_status:  apb_prdata = {29'd0, r_status};
                c_off_period:  apb_prdata = r_period;
                c_off_high:    apb_prdata = r_high;
                c_off_timeout: apb_prdata = r_timeout;
                default:       apb_prdata = 32'd0;
            endcase
        end
    end

    assign irq = r_ctrl[c_ctrl_irq_en] & (|r_status);

endmodule

`default_nettype wire

// File: tb/tb_apb_pwm_cap.sv
// ============================================================================
// Module   : tb_apb_pwm_cap
// Purpose  : Scoreboard bench for apb_pwm_cap with directed waveforms.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_pwm_cap;

    localparam logic [7:0] A_CTRL = 8'h40;
    localparam logic [7:0] A_STAT = 8'h44;
    localparam logic [7:0] A_PER  = 8'h48;
    localparam logic [7:0] A_HIGH = 8'h4C;
    localparam logic [7:0] A_TMO  = 8'h50;

    logic        clk;
    logic        rstn;
    logic        psel;
    logic [31:0] paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        cap_in;
    logic        irq;

    logic        wave_on;
    logic        wave_val;
    logic        man_val;
    int          wh;
    int          wl;
    int          ph;

    int          n_pass;
    int          n_chk;

    typedef struct {
        string       name;
        logic [31:0] data;
        bit          chk_irq;
        bit          irq;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    assign cap_in = wave_on ? wave_val : man_val;

    apb_pwm_cap #(.SYNC_STAGES(2)) dut (
        .apb_pclk    (clk),
        .apb_prstn   (rstn),
        .apb_psel    (psel),
        .apb_paddr   (paddr),
        .apb_penable (penable),
        .apb_pwrite  (pwrite),
        .apb_pwdata  (pwdata),
        .apb_prdata  (prdata),
        .cap_in      (cap_in),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running periodic source: high for wh cycles, low for wl cycles.
    always @(posedge clk) begin
        #1;
        if (!wave_on) begin
            ph       = 0;
            wave_val = 1'b0;
        end else begin
            wave_val = (ph < wh);
            ph       = (ph + 1 >= wh + wl) ? 0 : ph + 1;
        end
    end

    always @(negedge clk) begin
        if (psel && penable && !pwrite) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_read: prdata=%h with empty scoreboard", prdata);
            end else begin
                e = sb.pop_front();
                if (prdata === e.data) n_pass++;
                else $display("FAIL %s: prdata=%h expected %h", e.name, prdata, e.data);
                if (e.chk_irq) begin
                    n_chk++;
                    if (irq === e.irq) n_pass++;
                    else $display("FAIL %s_irq: irq=%b expected %b", e.name, irq, e.irq);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [31:0] d, input bit ci, input bit ie);
        exp_t t;
        t.name = nm; t.data = d; t.chk_irq = ci; t.irq = ie;
        sb.push_back(t);
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = {24'd0, a}; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input string nm, input logic [31:0] d,
                            input bit ci = 1'b0, input bit ie = 1'b0);
        push(nm, d, ci, ie);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {24'd0, a};
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Access phase held for two cycles to sample consecutive register states.
    task automatic apb_read2(input logic [7:0] a, input string n0, input logic [31:0] d0,
                             input string n1, input logic [31:0] d1);
        push(n0, d0, 1'b0, 1'b0);
        push(n1, d1, 1'b0, 1'b0);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {24'd0, a};
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        n_pass = 0; n_chk = 0;
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0;
        wave_on = 1'b0; man_val = 1'b0; wh = 3; wl = 7;
        tick(4);
        rstn = 1'b1;

        apb_read(A_CTRL, "rst_ctrl", 32'd0, 1'b1, 1'b0);
        apb_read(A_STAT, "rst_status", 32'd0);

        // Continuous capture H=3 L=7
        apb_write(A_CTRL, 32'h1);
        wave_on = 1'b1;
        tick(14);
        apb_read(A_STAT, "cont_status", 32'h1);
        apb_read(A_PER,  "cont_period", 32'd10);
        apb_read(A_HIGH, "cont_high",   32'd3);
        tick(20);
        apb_read(A_STAT, "cont_ovr", 32'h3, 1'b1, 1'b0);
        apb_write(A_CTRL, 32'h0);
        apb_read(A_STAT, "dis_keep_status", 32'h3);
        apb_write(A_STAT, 32'h3);
        apb_read(A_STAT, "w1c_clear", 32'h0);

        // Reset during an active measurement
        apb_write(A_TMO, 32'd1000);
        apb_write(A_CTRL, 32'h3);
        tick(30);
        apb_read(A_HIGH, "pre_rst_high", 32'd3, 1'b1, 1'b1);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        apb_read(A_CTRL, "mid_rst_ctrl",    32'd0);
        apb_read(A_STAT, "mid_rst_status",  32'd0, 1'b1, 1'b0);
        apb_read(A_PER,  "mid_rst_period",  32'd0);
        apb_read(A_HIGH, "mid_rst_high",    32'd0);
        apb_read(A_TMO,  "mid_rst_timeout", 32'd0);
        wave_on = 1'b0;

        // Oneshot with interrupt H=25 L=75
        wh = 25; wl = 75;
        apb_write(A_CTRL, 32'h7);
        wave_on = 1'b1;
        tick(110);
        apb_read(A_PER,  "os_period", 32'd100, 1'b1, 1'b1);
        apb_read(A_HIGH, "os_high",   32'd25);
        apb_read(A_STAT, "os_status", 32'h1);
        wave_on = 1'b0;
        wh = 10; wl = 10;
        tick(1);
        wave_on = 1'b1;
        tick(60);
        apb_read(A_PER,  "os_hold_period", 32'd100);
        apb_read(A_HIGH, "os_hold_high",   32'd25);
        apb_read(A_STAT, "os_hold_status", 32'h1, 1'b1, 1'b1);
        apb_write(A_STAT, 32'h1);
        apb_read(A_STAT, "os_w1c", 32'h0, 1'b1, 1'b0);
        apb_write(A_CTRL, 32'h0);
        wave_on = 1'b0;

        // Timeout: input held high after a rise
        apb_write(A_TMO, 32'd50);
        apb_write(A_CTRL, 32'h1);
        tick(3);
        man_val = 1'b1;
        repeat (50) @(posedge clk);
        apb_read2(A_STAT, "tmo_before", 32'h0, "tmo_at", 32'h4);
        apb_read(A_PER,  "tmo_period_kept", 32'd100);
        apb_read(A_HIGH, "tmo_high_kept",   32'd25);
        man_val = 1'b0;
        tick(6);
        man_val = 1'b1;
        tick(8);
        man_val = 1'b0;
        tick(4);
        man_val = 1'b1;
        tick(6);
        apb_read(A_PER,  "rearm_period", 32'd12);
        apb_read(A_HIGH, "rearm_high",   32'd8);
        apb_read(A_STAT, "rearm_status", 32'h5);
        man_val = 1'b0;

        // Disable in LO, then re-enable
        apb_write(A_CTRL, 32'h0);
        apb_write(A_STAT, 32'h7);
        apb_write(A_TMO, 32'd0);
        apb_write(A_CTRL, 32'h1);
        tick(2);
        man_val = 1'b1; tick(4);
        man_val = 1'b0; tick(6);
        man_val = 1'b1; tick(4);
        man_val = 1'b0; tick(3);
        apb_write(A_CTRL, 32'h0);
        apb_read(A_PER,  "dis_period", 32'd10);
        apb_read(A_HIGH, "dis_high",   32'd4);
        apb_read(A_STAT, "dis_status", 32'h1);
        apb_write(A_CTRL, 32'h1);
        tick(3);
        man_val = 1'b1; tick(2);
        man_val = 1'b0; tick(5);
        man_val = 1'b1; tick(2);
        man_val = 1'b0; tick(4);
        apb_read(A_PER,  "reen_period", 32'd7);
        apb_read(A_HIGH, "reen_high",   32'd2);
        apb_read(A_STAT, "reen_status", 32'h3);

        // PWM-like loop-back H=5 L=15 with W1C racing the completing rise
        apb_write(A_CTRL, 32'h0);
        apb_write(A_STAT, 32'h7);
        apb_write(A_CTRL, 32'h1);
        tick(3);
        man_val = 1'b1; tick(5);
        man_val = 1'b0; tick(15);
        man_val = 1'b1; tick(5);
        man_val = 1'b0; tick(15);
        man_val = 1'b1;
        apb_write(A_STAT, 32'h1);
        apb_read(A_STAT, "race_status", 32'h3, 1'b1, 1'b0);
        apb_read(A_PER,  "lb_period",   32'd20);
        apb_read(A_HIGH, "lb_high",     32'd5);

        // Unmapped and read-only accesses
        apb_read(8'h54, "unmapped_54", 32'd0);
        apb_read(8'h3C, "unmapped_3c", 32'd0);
        apb_write(A_PER, 32'hDEAD_BEEF);
        apb_read(A_PER, "ro_period", 32'd20);
        apb_write(A_CTRL, 32'hFFFF_FFF8);
        apb_read(A_CTRL, "ctrl_mask", 32'd0);

        tick(3);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
